// File: rtl/if_fetch_queue_if.sv
// Handshake bundle between the IF stage, the fetch queue and the ID stage.
// The queue uses the slave modport; the stage/bench driving it uses master.
interface if_fetch_queue_if #(
    parameter int WORD_LENGTH = 32,
    parameter int DEPTH       = 4
);
    logic                   in_valid;
    logic [WORD_LENGTH-1:0] in_pc;
    logic [WORD_LENGTH-1:0] in_instruction;
    logic                   in_ready;
    logic                   flush;
    logic                   out_valid;
    logic [WORD_LENGTH-1:0] out_pc;
    logic [WORD_LENGTH-1:0] out_instruction;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output in_valid, in_pc, in_instruction, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instruction, count
    );

    modport slave (
        input  in_valid, in_pc, in_instruction, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instruction, count
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Circular fetch queue between IF and ID with EMPTY/PARTIAL/FULL control FSM.
// Optional macro IF_FETCH_QUEUE_BYPASS_EN enables the empty-queue combinational bypass.
module if_fetch_queue #(
    parameter int WORD_LENGTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_FREE  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
    localparam logic [CW-1:0] ZERO_COUNT = CW'(0);
    localparam logic [AW-1:0] ONE_PTR    = AW'(1);
    localparam logic [AW-1:0] ZERO_PTR   = AW'(0);
    localparam logic [WORD_LENGTH-1:0] ZERO_WORD = WORD_LENGTH'(0);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WORD_LENGTH-1:0] r_mem_pc    [DEPTH];
    logic [WORD_LENGTH-1:0] r_mem_instr [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [WORD_LENGTH-1:0] r_out_pc;
    logic [WORD_LENGTH-1:0] r_out_instr;

    logic                   w_bypass_take;
    logic                   w_push;
    logic                   w_pop;
    logic [AW-1:0]          w_wr_ptr_nxt;
    logic [AW-1:0]          w_rd_ptr_nxt;
    logic [CW-1:0]          w_count_nxt;
    logic [WORD_LENGTH-1:0] w_head_pc_nxt;
    logic [WORD_LENGTH-1:0] w_head_instr_nxt;

`ifdef IF_FETCH_QUEUE_BYPASS_EN
    logic w_bypass_show;
    // An empty queue hands the incoming word straight to ID; it is stored only if ID stalls.
    assign w_bypass_show       = (r_state == EMPTY) & bus.in_valid & ~bus.flush;
    assign w_bypass_take       = w_bypass_show & bus.out_ready;
    assign bus.out_valid       = r_out_valid | w_bypass_show;
    assign bus.out_pc          = w_bypass_show ? bus.in_pc : r_out_pc;
    assign bus.out_instruction = w_bypass_show ? bus.in_instruction : r_out_instr;
`else
    assign w_bypass_take       = 1'b0;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_pc          = r_out_pc;
    assign bus.out_instruction = r_out_instr;
`endif

    assign bus.in_ready = r_in_ready;
    assign bus.count    = r_count;

    assign w_push = bus.in_valid & r_in_ready & ~bus.flush & ~w_bypass_take;
    assign w_pop  = r_out_valid & bus.out_ready & ~bus.flush;

    // Next pointers, occupancy and the entry that will sit at the head after this edge.
    always_comb begin
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_count_nxt      = r_count;
        w_head_pc_nxt    = ZERO_WORD;
        w_head_instr_nxt = ZERO_WORD;
        if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + ONE_PTR;
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + ONE_PTR;
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + ONE_COUNT;
            2'b01:   w_count_nxt = r_count - ONE_COUNT;
            default: w_count_nxt = r_count;
        endcase
        // The word being written this cycle is not in storage yet, so forward it.
        if (w_count_nxt == ZERO_COUNT) begin
            w_head_pc_nxt    = ZERO_WORD;
            w_head_instr_nxt = ZERO_WORD;
        end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_pc_nxt    = bus.in_pc;
            w_head_instr_nxt = bus.in_instruction;
        end else begin
            w_head_pc_nxt    = r_mem_pc[w_rd_ptr_nxt];
            w_head_instr_nxt = r_mem_instr[w_rd_ptr_nxt];
        end
    end

    // Entry storage; contents are left alone on reset and flush.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= bus.in_pc;
            r_mem_instr[r_wr_ptr] <= bus.in_instruction;
        end
    end

    // Control FSM with registered pointers, occupancy and head outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_wr_ptr    <= ZERO_PTR;
            r_rd_ptr    <= ZERO_PTR;
            r_count     <= ZERO_COUNT;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_pc    <= ZERO_WORD;
            r_out_instr <= ZERO_WORD;
        end else if (bus.flush) begin
            r_state     <= EMPTY;
            r_wr_ptr    <= ZERO_PTR;
            r_rd_ptr    <= ZERO_PTR;
            r_count     <= ZERO_COUNT;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_pc    <= ZERO_WORD;
            r_out_instr <= ZERO_WORD;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != FULL_COUNT);
            r_out_valid <= (w_count_nxt != ZERO_COUNT);
            r_out_pc    <= w_head_pc_nxt;
            r_out_instr <= w_head_instr_nxt;
            case (r_state)
                EMPTY: begin
                    if (w_push) r_state <= PARTIAL;
                    else        r_state <= EMPTY;
                end
                PARTIAL: begin
                    if (w_push && !w_pop && (r_count == LAST_FREE))      r_state <= FULL;
                    else if (w_pop && !w_push && (r_count == ONE_COUNT)) r_state <= EMPTY;
                    else                                                 r_state <= PARTIAL;
                end
                FULL: begin
                    if (w_pop) r_state <= PARTIAL;
                    else       r_state <= FULL;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: scenario tasks plus a push-order scoreboard.
module tb_if_fetch_queue;
    localparam int WL    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [WL-1:0] sb_pc  [$];
    logic [WL-1:0] sb_ins [$];

    if_fetch_queue_if #(.WORD_LENGTH(WL), .DEPTH(DEPTH)) bus ();

    if_fetch_queue #(.WORD_LENGTH(WL), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: drive at negedge, check head against the scoreboard, update at posedge.
    task automatic cycle(input logic v, input logic [WL-1:0] pc, input logic [WL-1:0] ins,
                         input logic ordy, output logic acc,
                         output logic obs_v, output logic [WL-1:0] obs_pc);
        logic          byp;
        logic          exp_v;
        logic          pop;
        logic [WL-1:0] e_pc;
        logic [WL-1:0] e_ins;
        @(negedge clk);
        bus.in_valid       = v;
        bus.in_pc          = pc;
        bus.in_instruction = ins;
        bus.out_ready      = ordy;
        bus.flush          = 1'b0;
        #1;
        byp = 1'b0;
`ifdef IF_FETCH_QUEUE_BYPASS_EN
        byp = (sb_pc.size() == 0) && v;
`endif
        exp_v = (sb_pc.size() != 0) || byp;
        if (sb_pc.size() != 0) begin
            e_pc = sb_pc[0]; e_ins = sb_ins[0];
        end else if (byp) begin
            e_pc = pc; e_ins = ins;
        end else begin
            e_pc = 32'h0; e_ins = 32'h0;
        end
        obs_v  = bus.out_valid;
        obs_pc = bus.out_pc;
        n_tests++;
        if (bus.out_valid !== exp_v || bus.out_pc !== e_pc || bus.out_instruction !== e_ins ||
            bus.in_ready !== (sb_pc.size() < DEPTH) || bus.count !== CW'(sb_pc.size())) begin
            n_fail++;
            $display("FAIL head: got v=%b pc=%h ins=%h rdy=%b cnt=%0d, want v=%b pc=%h ins=%h rdy=%b cnt=%0d",
                     bus.out_valid, bus.out_pc, bus.out_instruction, bus.in_ready, bus.count,
                     exp_v, e_pc, e_ins, (sb_pc.size() < DEPTH), sb_pc.size());
        end
        pop = exp_v && ordy;
        acc = v && (sb_pc.size() < DEPTH) && !(byp && ordy);
        @(posedge clk);
        if (pop && sb_pc.size() != 0) begin
            void'(sb_pc.pop_front());
            void'(sb_ins.pop_front());
        end
        if (acc) begin
            sb_pc.push_back(pc);
            sb_ins.push_back(ins);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_pc = 32'h0; bus.in_instruction = 32'h0;
        bus.out_ready = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.in_ready !== 1'b1 ||
            bus.out_pc !== 32'h0 || bus.out_instruction !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: got v=%b cnt=%0d rdy=%b pc=%h ins=%h, want 0 0 1 0 0",
                     bus.out_valid, bus.count, bus.in_ready, bus.out_pc, bus.out_instruction);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_push();
        logic acc, ov;
        logic [WL-1:0] opc;
        cycle(1'b1, 32'h4, 32'hE3A01005, 1'b1, acc, ov, opc);
        #1;
        n_tests++;
`ifdef IF_FETCH_QUEUE_BYPASS_EN
        if (ov !== 1'b1 || opc !== 32'h4 || bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_push: got v=%b pc=%h cnt=%0d, want v=1 pc=4 cnt=0", ov, opc, bus.count);
        end
`else
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4 || bus.out_instruction !== 32'hE3A01005 ||
            bus.count !== 3'd1) begin
            n_fail++;
            $display("FAIL first_push: got v=%b pc=%h ins=%h cnt=%0d, want v=1 pc=4 ins=e3a01005 cnt=1",
                     bus.out_valid, bus.out_pc, bus.out_instruction, bus.count);
        end
`endif
        cycle(1'b0, 32'h0, 32'h0, 1'b1, acc, ov, opc);
        #1;
        n_tests++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_drain: got cnt=%0d v=%b, want cnt=0 v=0", bus.count, bus.out_valid);
        end
    endtask

    task automatic test_fill();
        logic acc, ov;
        logic [WL-1:0] opc;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'(4 + 4 * i), 32'hA0000000 | 32'(i), 1'b0, acc, ov, opc);
            #1;
            n_tests++;
            if (i < 3) begin
                if (bus.in_ready !== 1'b1 || bus.count !== CW'(i + 1)) begin
                    n_fail++;
                    $display("FAIL fill_%0d: got rdy=%b cnt=%0d, want rdy=1 cnt=%0d", i, bus.in_ready, bus.count, i + 1);
                end
            end else begin
                if (bus.in_ready !== 1'b0 || bus.count !== 3'd4 || bus.out_pc !== 32'h4) begin
                    n_fail++;
                    $display("FAIL full_%0d: got rdy=%b cnt=%0d pc=%h, want rdy=0 cnt=4 pc=4",
                             i, bus.in_ready, bus.count, bus.out_pc);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic acc, ov;
        logic [WL-1:0] opc;
        logic [WL-1:0] p = 32'h14;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, p, 32'hB0000000 | p, 1'b1, acc, ov, opc);
            n_tests++;
            if (ov !== 1'b1 || opc !== 32'(4 + 4 * c)) begin
                n_fail++;
                $display("FAIL wrap_pop_%0d: got v=%b pc=%h, want v=1 pc=%h", c, ov, opc, 32'(4 + 4 * c));
            end
            if (acc) p = p + 32'h4;
        end
        #1;
        n_tests++;
        if (bus.count !== 3'd3 || bus.out_pc !== 32'h24 || bus.out_instruction !== 32'hB0000024) begin
            n_fail++;
            $display("FAIL wrap_end: got cnt=%0d pc=%h ins=%h, want cnt=3 pc=24 ins=b0000024",
                     bus.count, bus.out_pc, bus.out_instruction);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_pc = 32'h30; bus.in_instruction = 32'hCAFE0030;
        bus.out_ready = 1'b1; bus.flush = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.count !== 3'd3) begin
            n_fail++;
            $display("FAIL flush_pre: got v=%b cnt=%0d, want v=1 cnt=3", bus.out_valid, bus.count);
        end
        @(posedge clk);
        #1;
        sb_pc.delete(); sb_ins.delete();
        n_tests++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_instruction !== 32'h0 ||
            bus.out_pc !== 32'h0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_post: got cnt=%0d v=%b pc=%h ins=%h rdy=%b, want 0 0 0 0 1",
                     bus.count, bus.out_valid, bus.out_pc, bus.out_instruction, bus.in_ready);
        end
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stored: got cnt=%0d v=%b, want cnt=0 v=0", bus.count, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, ov;
        logic [WL-1:0] opc;
        for (int c = 0; c < 60; c++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 3) != 0), acc, ov, opc);
        end
        for (int c = 0; c < 8 && sb_pc.size() != 0; c++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, acc, ov, opc);
        end
        #1;
        n_tests++;
        if (bus.count !== 3'd0 || sb_pc.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got cnt=%0d left=%0d, want 0 0", bus.count, sb_pc.size());
        end
    endtask

    task automatic test_async_reset();
        logic acc, ov;
        logic [WL-1:0] opc;
        cycle(1'b1, 32'h100, 32'hC0, 1'b0, acc, ov, opc);
        cycle(1'b1, 32'h104, 32'hC1, 1'b0, acc, ov, opc);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.in_ready !== 1'b1 || bus.out_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b cnt=%0d rdy=%b pc=%h, want 0 0 1 0",
                     bus.out_valid, bus.count, bus.in_ready, bus.out_pc);
        end
        sb_pc.delete(); sb_ins.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        cycle(1'b1, 32'h200, 32'hD0, 1'b0, acc, ov, opc);
        #1;
        n_tests++;
        if (bus.count !== 3'd1 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL post_reset_push: got cnt=%0d v=%b pc=%h, want 1 1 200",
                     bus.count, bus.out_valid, bus.out_pc);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, acc, ov, opc);
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fill();
        test_wrap();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter WORD_LENGTH, default 32, width of PC and instruction fields.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  IF stage presents a fetched instruction.
REQ-006 in_pc  input  WORD_LENGTH  PC+4 value from IF.
REQ-007 in_instruction  input  WORD_LENGTH  instruction word from IF.
REQ-008 in_ready  output  1  queue accepts a push; IF freeze equals ~in_ready.
REQ-009 flush  input  1  branch taken; discard all queued and incoming entries.
REQ-010 out_valid  output  1  head entry presented to ID.
REQ-011 out_pc  output  WORD_LENGTH  head PC.
REQ-012 out_instruction  output  WORD_LENGTH  head instruction.
REQ-013 out_ready  input  1  ID consumes head (ID not frozen).
REQ-014 count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Push SHALL occur when in_valid and in_ready; pop SHALL occur when out_valid and out_ready.
REQ-016 in_ready SHALL be 1 iff count < DEPTH; a pop in the same cycle SHALL NOT make a full queue ready.
REQ-017 Storage SHALL be a circular buffer with write and read pointers of clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-018 Control state SHALL be one of EMPTY (count 0), PARTIAL (0 < count < DEPTH), FULL (count DEPTH).
REQ-019 EMPTY->PARTIAL on push; PARTIAL->EMPTY on pop without push at count 1; PARTIAL->FULL on push without pop at count DEPTH-1; FULL->PARTIAL on pop; any state->EMPTY on flush.
REQ-020 Simultaneous push and pop in PARTIAL SHALL leave count unchanged and advance both pointers.
REQ-021 Entry pushed in cycle n SHALL appear at head with out_valid=1 in cycle n+1 when the queue was empty.
REQ-022 out_valid SHALL be 1 iff state is not EMPTY; out_pc and out_instruction SHALL be the head entry, and SHALL be 0 when out_valid is 0 (bubble = NOP).
REQ-023 Entries SHALL leave in push order; no entry SHALL be duplicated or dropped except by flush.
REQ-024 flush SHALL take effect at the next edge: pointers and count to 0, state EMPTY; push and pop in the flush cycle SHALL be ignored.
REQ-025 During a flush cycle out_valid SHALL still reflect pre-flush state; ID discards using its own flush.

Reset
REQ-026 rst asserted SHALL immediately force state EMPTY, pointers 0, count 0, out_valid 0, out_pc 0, out_instruction 0, in_ready 1.
REQ-027 rst asserted mid-operation SHALL discard all entries; storage contents need not be cleared.
REQ-028 First push SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-029 Macro IF_FETCH_QUEUE_BYPASS_EN SHALL select empty-queue bypass.
REQ-030 With macro defined: in EMPTY with in_valid=1 and flush=0, out_valid SHALL be 1 and out_* SHALL equal in_* combinationally; if out_ready=1 the entry SHALL NOT be stored and count stays 0; if out_ready=0 it SHALL be pushed normally.
REQ-031 Without macro: no combinational path from in_* to out_*; latency per REQ-021.

Verification
REQ-032 Reset then push pc=0x4/instr=0xE3A01005 with out_ready=1 -> next cycle out_valid=1, out_pc=0x4, out_instruction=0xE3A01005, count=1 (bypass build: same cycle, count=0).
REQ-033 out_ready=0, push 5 consecutive entries pc=0x4..0x14 (DEPTH=4) -> in_ready=0 after 4th, 5th not accepted, count=4, head pc=0x4.
REQ-034 Full queue, out_ready=1 and in_valid=1 for 8 cycles -> pops pc 0x4,0x8,0xC,0x10,... in order, pointers wrap, no loss.
REQ-035 count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_instruction=0, flushed input not stored.
REQ-036 rst asserted asynchronously between edges with count=2 -> out_valid=0, count=0 before the next edge.
